// File: rtl/i2s_tx_fifo_reader_pkg.sv
// rtl/i2s_tx_fifo_reader_pkg.sv - shared audio types and constants for the I2S transmit reader
// Package kosei_audio_pkg: FSM state enum, I2S framing constant, underrun counter width
// and a saturating increment helper.
package kosei_audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Philips I2S: MSB follows the word-select change by one bit clock.
    localparam int I2S_DELAY_BITS = 1;

    localparam int UNDERRUN_CNT_W = 16;

    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_tx_fifo_reader_if.sv
// rtl/i2s_tx_fifo_reader_if.sv - FIFO read port plus I2S pins bundle
// Signals:
//   fifo_rd_en   pop request toward the FIFO (one cycle)
//   fifo_rd_data registered FIFO data, valid the cycle after fifo_rd_en
//   fifo_empty   FIFO empty flag
//   bclk, lrclk, sdata  I2S serial outputs
// Modports: master = the reader, slave = FIFO / pin side.
interface i2s_tx_fifo_reader_if #(
    parameter int WIDTH = 24
);
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_empty;
    logic             bclk;
    logic             lrclk;
    logic             sdata;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        output bclk,
        output lrclk,
        output sdata
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        input  bclk,
        input  lrclk,
        input  sdata
    );
endinterface

// File: rtl/i2s_tx_fifo_reader_bclk_gen.sv
// rtl/i2s_tx_fifo_reader_bclk_gen.sv - I2S bit clock divider with edge event strobes
// Ports:
//   clk, rst  system clock, async active-high reset
//   i_run     divider runs while high; held cleared (bclk=0) while low
//   o_bclk    registered bit clock
//   o_rise    high in the clk cycle whose closing edge raises bclk
//   o_fall    high in the clk cycle whose closing edge drops bclk
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_bclk,
    output logic o_rise,
    output logic o_fall
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] LP_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_bclk;
    logic          w_wrap;

    assign w_wrap = i_run && (r_div_cnt == LP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (!i_run) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_bclk = r_bclk;
    assign o_rise = w_wrap & ~r_bclk;
    assign o_fall = w_wrap & r_bclk;

endmodule

// File: rtl/i2s_tx_fifo_reader.sv
// rtl/i2s_tx_fifo_reader.sv - FIFO consumer serialising L/R samples as Philips I2S
// Ports:
//   clk, rst           system clock, async active-high reset
//   i_enable           start / continue streaming
//   o_busy             high while not IDLE
//   o_underrun_pulse   one-cycle pulse per slot played as silence
//   o_underrun_count   saturating underrun count, cleared only by rst
//   bus (master)       FIFO read port and I2S bclk/lrclk/sdata
module i2s_tx_fifo_reader
    import kosei_audio_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    output logic                      o_busy,
    output logic                      o_underrun_pulse,
    output logic [UNDERRUN_CNT_W-1:0] o_underrun_count,
    i2s_tx_fifo_reader_if.master      bus
);
    localparam int BW = $clog2(SLOT_BITS);
    localparam logic [BW-1:0] LP_LAST_BIT  = BW'(SLOT_BITS - 1);
    // The falling edge that ends this bit loads the shifter and presents the MSB.
    localparam logic [BW-1:0] LP_LOAD_BIT  = BW'(I2S_DELAY_BITS - 1);
    // Falling edges ending bits below this one still shift out sample bits.
    localparam logic [BW-1:0] LP_SHIFT_END = BW'(WIDTH + I2S_DELAY_BITS - 1);

    state_t                    r_state;
    logic                      r_busy;
    logic [BW-1:0]             r_bit_idx;
    logic                      r_lrclk;
    logic                      r_sdata;
    logic [WIDTH-1:0]          r_shift;
    logic [WIDTH-1:0]          r_hold;
    logic                      r_fifo_rd_en;
    logic                      r_rd_pend;
    logic                      r_underrun_pulse;
    logic [UNDERRUN_CNT_W-1:0] r_underrun_count;

    logic w_bclk;
    logic w_bclk_rise;
    logic w_bclk_fall;
    logic w_slot_end;
    logic w_stop;
    logic w_fetch;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk    (clk),
        .rst    (rst),
        .i_run  (r_state != ST_IDLE),
        .o_bclk (w_bclk),
        .o_rise (w_bclk_rise),
        .o_fall (w_bclk_fall)
    );

    // Last falling edge of a slot: the next slot's k=0 starts on this edge.
    assign w_slot_end = w_bclk_fall && (r_bit_idx == LP_LAST_BIT);
    // Stopping only at the end of a right slot keeps frames whole; enable being
    // high on that edge keeps streaming without a gap.
    assign w_stop     = w_slot_end && r_lrclk && !i_enable;
    // Fetch on entry and at every slot boundary except the stopping one, so the
    // pop strobe lands in the first clk of k=0.
    assign w_fetch    = ((r_state == ST_IDLE) && i_enable) || (w_slot_end && !w_stop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_busy           <= 1'b0;
            r_bit_idx        <= '0;
            r_lrclk          <= 1'b0;
            r_sdata          <= 1'b0;
            r_shift          <= '0;
            r_hold           <= '0;
            r_fifo_rd_en     <= 1'b0;
            r_rd_pend        <= 1'b0;
            r_underrun_pulse <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_fifo_rd_en     <= 1'b0;
            r_underrun_pulse <= 1'b0;
            // FIFO data is registered: valid the cycle after the pop.
            r_rd_pend        <= r_fifo_rd_en;
            if (r_rd_pend) begin
                r_hold <= bus.fifo_rd_data;
            end

            case (r_state)
                ST_IDLE: begin
                    r_bit_idx <= '0;
                    r_lrclk   <= 1'b0;
                    r_sdata   <= 1'b0;
                    if (i_enable) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (w_stop) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_bit_idx <= '0;
                        r_lrclk   <= 1'b0;
                        r_sdata   <= 1'b0;
                        r_shift   <= '0;
                    end else begin
                        r_state <= i_enable ? ST_RUN : ST_DRAIN;
                        if (w_bclk_fall) begin
                            if (r_bit_idx == LP_LAST_BIT) begin
                                r_bit_idx <= '0;
                                r_lrclk   <= ~r_lrclk;
                                r_sdata   <= 1'b0;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                                if (r_bit_idx == LP_LOAD_BIT) begin
                                    r_sdata <= r_hold[WIDTH-1];
                                    r_shift <= {r_hold[WIDTH-2:0], 1'b0};
                                end else if (r_bit_idx < LP_SHIFT_END) begin
                                    r_sdata <= r_shift[WIDTH-1];
                                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                                end else begin
                                    r_sdata <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // An empty FIFO never sees a pop; the slot plays silence instead.
            if (w_fetch) begin
                if (!bus.fifo_empty) begin
                    r_fifo_rd_en <= 1'b1;
                end else begin
                    r_hold           <= '0;
                    r_underrun_pulse <= 1'b1;
                    r_underrun_count <= sat_inc(r_underrun_count);
                end
            end
        end
    end

    assign bus.fifo_rd_en = r_fifo_rd_en;
    assign bus.bclk       = w_bclk;
    assign bus.lrclk      = r_lrclk;
    assign bus.sdata      = r_sdata;
    assign o_busy           = r_busy;
    assign o_underrun_pulse = r_underrun_pulse;
    assign o_underrun_count = r_underrun_count;

    // The receiver samples on bclk rising edges; nothing here changes on them.
    logic w_unused;
    assign w_unused = w_bclk_rise;

endmodule

// File: doc/i2s_tx_fifo_reader.md
Name: i2s_tx_fifo_reader

Overview:
- Read-side consumer of the sample FIFO. It pops interleaved L/R samples through the FIFO's read port (rd_en, registered rd_data, empty) and serialises them as a Philips I2S stream: BCLK, LRCLK and SDATA, MSB first, with a one-bit delay.
- Sits between the sample FIFO and the chip's DAC/I2S pins.
- Detects FIFO underrun, substitutes silence for the affected slot, and counts the events.

Parameters:
- WIDTH, 24, sample width in bits; equals the FIFO data width.
- SLOT_BITS, 32, BCLK periods per channel slot; must be at least WIDTH+1.
- BCLK_DIV, 2, clk cycles per BCLK half-period; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  start/continue streaming.
- fifo_rd_en  out  1  one-cycle pop request to the FIFO.
- fifo_rd_data  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select (0 = left, 1 = right).
- sdata  out  1  I2S serial data.
- busy  out  1  high while not IDLE.
- underrun_pulse  out  1  one-cycle pulse per underrun slot.
- underrun_count  out  16  saturating underrun count.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: every output is 0, state is IDLE, and all counters and registers are cleared. Reset asserted mid-frame aborts the frame immediately; there is no partial-frame recovery.
- States:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN when enable returns to 1.
  - DRAIN -> IDLE at the end of the last bit of the right slot.
  - In IDLE, bclk, lrclk and sdata are held at 0 and no FIFO reads are issued.
- Bit timing:
  - div_cnt counts 0..BCLK_DIV-1. At wrap, bclk toggles; bclk is 0 on entry to RUN.
  - lrclk and sdata change only on bclk falling events; the receiver samples on rising edges.
  - One BCLK period = 2*BCLK_DIV clk. One frame = 2*SLOT_BITS BCLK periods.
- Slot bit index k, 0..SLOT_BITS-1, within each lrclk phase:
  - k=0: sdata=0 (I2S one-bit delay).
  - k=1..WIDTH: sample bits MSB..LSB.
  - k>WIDTH: sdata=0.
  - lrclk toggles at k=0 of each slot.
- Fetch:
  - At the first clk of k=0 of each slot, the block pulses fifo_rd_en for exactly 1 cycle if fifo_empty=0.
  - fifo_rd_data is captured into the hold register 2 cycles after the pulse.
  - The shift register loads from hold at the k=1 falling event. This is at least 2*BCLK_DIV ≥ 4 clk after the fetch, so no hazard exists.
- Entry into RUN: the entry cycle is the first cycle of a left slot with k=0, and the fetch is issued in that cycle. The first sample popped after entry is always the left channel.
- Underrun:
  - If fifo_empty=1 at the fetch cycle, there is no pop and the hold register is forced to 0, so the slot is silent.
  - underrun_pulse goes high for 1 cycle. underrun_count increments and saturates at 16'hFFFF; only rst clears it.
  - Channel alignment is not re-synchronised: the next pop goes to the next slot.
- DRAIN: fetches continue until the right slot's fetch of the current frame. No fetch is issued for a following frame.
- Simultaneous events:
  - enable falling during a left slot: the right slot of that frame still pops and plays.
  - enable rising in the same cycle DRAIN would exit: the block stays in RUN with no gap.
- fifo_rd_en is never asserted while fifo_empty=1.

Decomposition:
- Shared package (kosei_audio_pkg) holds:
  - state enum IDLE/RUN/DRAIN;
  - I2S_DELAY_BITS=1;
  - underrun counter width 16.
- One natural sub-module: i2s_bclk_gen, containing div_cnt, bclk, and rise/fall event strobes. The FSM, fetch logic and shifter stay in the top module.

Test Plan:
- Reset and idle, with WIDTH=24, SLOT_BITS=32, BCLK_DIV=2: rst pulse with enable=0 -> all outputs 0, fifo_rd_en never asserted over 1000 clk.
- Basic frame: FIFO preloaded L=24'hA5C3F0, R=24'h123456; enable=1 -> SDATA captured on bclk rising edges gives:
  - lrclk=0 slot: bit0=0, bits1..24=A5C3F0, bits25..31=0;
  - lrclk=1 slot: 123456;
  - frame length 256 clk;
  - exactly 2 fifo_rd_en pulses.
- Underrun: FIFO holds only L=24'h7FFFFF -> right slot all zeros, underrun_pulse once, underrun_count=1, no fifo_rd_en while empty.
- Drain: enable dropped mid-left slot -> right sample still popped and sent, busy falls after bit 31 of the right slot, no further pops, lines return to 0.
- Saturation: continuously empty FIFO for 65540 slots with a forced-counter shortcut allowed -> underrun_count holds 16'hFFFF.
- Async reset mid-frame: rst asserted between clk edges during bit 10 -> outputs 0 immediately with no clk edge needed; after release and enable, the first pop again maps to left.
